// File: rtl/fsqrt_seq_pkg.sv
// Shared types and constants for the sequential single-precision square-root unit.
package fsqrt_seq_pkg;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  typedef enum logic [2:0] {ZERO, DENORM, INF, NAN, NEG, NORMAL} cls_t;

  localparam int ITER = 25;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;

  // Radicand is consumed two bits per iteration; remainder needs two guard bits over the root.
  localparam int RAD_W = 2 * ITER;
  localparam int REM_W = ITER + 3;

endpackage

// File: rtl/fsqrt_classify.sv
// Combinational operand classifier: picks the operand class and the bypass result for specials.
module fsqrt_classify
  import fsqrt_seq_pkg::*;
(
  input  logic [31:0] x,
  output cls_t        cls,
  output logic [31:0] special,
  output logic        nv
);

  logic        sign;
  logic [7:0]  e;
  logic [22:0] m;

  assign sign = x[31];
  assign e    = x[30:23];
  assign m    = x[22:0];

  // Denormals flush to zero before the sign test, so -denorm yields -0 without nv.
  always_comb begin
    cls     = NORMAL;
    special = '0;
    nv      = 1'b0;
    if (e == 8'hFF && m != '0) begin
      cls     = NAN;
      special = QNAN;
    end else if (e == 8'h00) begin
      cls     = (m == '0) ? ZERO : DENORM;
      special = {sign, 31'd0};
    end else if (sign) begin
      cls     = NEG;
      special = QNAN;
      nv      = 1'b1;
    end else if (e == 8'hFF) begin
      cls     = INF;
      special = PINF;
    end
  end

endmodule

// File: rtl/fsqrt_seq.sv
// Radix-2 restoring square root, one root bit per cycle, RNE rounding, valid/ready on both sides.
module fsqrt_seq
  import fsqrt_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        nv
);

  state_t           state;
  logic [4:0]       cnt;
  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem;
  logic [ITER-1:0]  root;
  logic [7:0]       exp_r;

  cls_t             cls;
  logic [31:0]      special;
  logic             special_nv;

  logic [24:0]      rad_init;
  logic [7:0]       exp_init;
  logic [REM_W-1:0] rem_sh;
  logic [REM_W-1:0] trial;
  logic             fits;

  fsqrt_classify u_classify (
    .x       (x),
    .cls     (cls),
    .special (special),
    .nv      (special_nv)
  );

  assign in_ready = (state == IDLE);

  // Odd biased exponent means an even true exponent; otherwise pre-shift the significand by one.
  assign rad_init = x[23] ? {2'b01, x[22:0]} : {1'b1, x[22:0], 1'b0};
  // (e + 126 + e[0]) / 2 rewritten without a 9-bit intermediate.
  assign exp_init = {1'b0, x[30:24]} + 8'((BIAS - 1) / 2) + {7'd0, x[23]};

  assign rem_sh = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
  assign trial  = {1'b0, root, 2'b01};
  assign fits   = (rem_sh >= trial);

  function automatic logic [31:0] round_rne(input logic [ITER-1:0] rt,
                                            input logic            sticky,
                                            input logic [7:0]      ex);
    logic        inc;
    logic [24:0] sum;
    logic [7:0]  eo;
    logic [22:0] mo;
    inc = rt[0] & (sticky | rt[1]);
    sum = {1'b0, rt[ITER-1:1]} + {24'd0, inc};
    if (sum[24]) begin
      eo = ex + 8'd1;
      mo = sum[23:1];
    end else begin
      eo = ex;
      mo = sum[22:0];
    end
    return {1'b0, eo, mo};
  endfunction

  // Control and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      nv        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (cls == NORMAL) begin
              cnt   <= '0;
              state <= CALC;
            end else begin
              y     <= special;
              nv    <= special_nv;
              state <= DONE;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= ROUND;
        end
        ROUND: begin
          y     <= round_rne(root, rem != '0, exp_r);
          nv    <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Recurrence datapath: loaded while idle, advanced once per CALC cycle
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      rad   <= {rad_init, 25'd0};
      rem   <= '0;
      root  <= '0;
      exp_r <= exp_init;
    end else if (state == CALC) begin
      rad  <= {rad[RAD_W-3:0], 2'b00};
      rem  <= fits ? (rem_sh - trial) : rem_sh;
      root <= {root[ITER-2:0], fits};
    end
  end

endmodule

// File: tb/tb_fsqrt_seq.sv
// Directed bench for fsqrt_seq: real-arithmetic reference model, literal vectors, latency and handshake checks.
module tb_fsqrt_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        nv;

  int n_vec;
  int n_bad;

  logic [31:0] xq[$];
  logic [32:0] eq[$];

  fsqrt_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .nv        (nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: IEEE rules for specials, otherwise double-precision sqrt rounded to single (RNE).
  function automatic logic [32:0] ref_sqrt(input logic [31:0] a);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [63:0] db;
    logic [63:0] rb;
    real         r;
    logic [10:0] re;
    logic [51:0] rm;
    logic [24:0] mant;
    logic [7:0]  ye;
    s = a[31];
    e = a[30:23];
    m = a[22:0];
    if (e == 8'hFF && m != 0) return {1'b0, 32'h7FC00000};
    if (e == 8'h00) return {1'b0, s, 31'd0};
    if (s) return {1'b1, 32'h7FC00000};
    if (e == 8'hFF) return {1'b0, 32'h7F800000};
    db = {1'b0, 11'(e) + 11'd896, m, 29'd0};
    r  = $sqrt($bitstoreal(db));
    rb = $realtobits(r);
    re = rb[62:52];
    rm = rb[51:0];
    ye = 8'(re - 11'd896);
    mant = {2'b01, rm[51:29]};
    if (rm[28] && ((|rm[27:0]) || mant[0])) mant = mant + 25'd1;
    if (mant[24]) begin
      ye   = ye + 8'd1;
      mant = mant >> 1;
    end
    return {1'b0, 1'b0, ye, mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle a result is presented it must match the oldest accepted operand.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_vec++;
      if (eq.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_out_valid: got y=%h nv=%b, expected no result", y, nv);
      end else begin
        if ({nv, y} !== eq[0]) begin
          n_bad++;
          $display("FAIL model_y x=%h: got y=%h nv=%b, expected y=%h nv=%b",
                   xq[0], y, nv, eq[0][31:0], eq[0][32]);
        end
        if (out_ready) begin
          void'(eq.pop_front());
          void'(xq.pop_front());
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] xv, input logic lit, input logic [31:0] lit_y,
                        input logic lit_nv, input int hold);
    int          lat;
    int          want_lat;
    logic [31:0] y0;
    logic        nv0;
    want_lat = (xv[30:23] != 8'h00 && xv[30:23] != 8'hFF && !xv[31]) ? 27 : 1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    x = xv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = $urandom;
    xq.push_back(xv);
    eq.push_back(ref_sqrt(xv));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(want_lat));
    if (lat == 0) begin
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "no result within 40 cycles");
    end
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    if (lit) begin
      chk("y_literal", y, lit_y);
      chk("nv_literal", 32'(nv), 32'(lit_nv));
    end
    y0  = y;
    nv0 = nv;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_y", y, y0);
      chk("hold_nv", 32'(nv), 32'(nv0));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [32:0] mr;
    logic [22:0] mm;
    logic [7:0]  ee;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_nv", 32'(nv), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    mr = ref_sqrt(32'h40800000); chk("model_4", mr[31:0], 32'h40000000);
    mr = ref_sqrt(32'h40000000); chk("model_2", mr[31:0], 32'h3FB504F3);
    mr = ref_sqrt(32'h3F000000); chk("model_half", mr[31:0], 32'h3F3504F3);
    mr = ref_sqrt(32'hC0800000); chk("model_neg", {31'd0, mr[32]}, 32'd1);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(32'h40800000, 1'b1, 32'h40000000, 1'b0, 0);
    run_op(32'h41100000, 1'b1, 32'h40400000, 1'b0, 0);
    run_op(32'h40000000, 1'b1, 32'h3FB504F3, 1'b0, 0);
    run_op(32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 0);
    run_op(32'hC0800000, 1'b1, 32'h7FC00000, 1'b1, 0);
    run_op(32'h80000000, 1'b1, 32'h80000000, 1'b0, 0);
    run_op(32'h00000000, 1'b1, 32'h00000000, 1'b0, 0);
    run_op(32'h7F800000, 1'b1, 32'h7F800000, 1'b0, 0);
    run_op(32'h00000001, 1'b1, 32'h00000000, 1'b0, 0);
    run_op(32'h80000001, 1'b1, 32'h80000000, 1'b0, 0);
    run_op(32'hFF800000, 1'b1, 32'h7FC00000, 1'b1, 0);
    run_op(32'h7FC00001, 1'b1, 32'h7FC00000, 1'b0, 0);
    run_op(32'hFFC00000, 1'b1, 32'h7FC00000, 1'b0, 0);
    run_op(32'h00800000, 1'b1, 32'h20000000, 1'b0, 0);
    run_op(32'h7F7FFFFF, 1'b0, 32'h0, 1'b0, 0);

    // Backpressure, then an operand offered right after the handshake edge
    run_op(32'h41100000, 1'b1, 32'h40400000, 1'b0, 10);
    run_op(32'h40800000, 1'b1, 32'h40000000, 1'b0, 0);

    // Abort mid-recurrence
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    x = 32'h40000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready_now", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("abort_quiet", 32'(out_valid), 32'd0);
    run_op(32'h41100000, 1'b1, 32'h40400000, 1'b0, 0);

    // Mantissa sweep at two exponents of opposite parity
    for (int i = 0; i < 2; i++) begin
      ee = (i == 0) ? 8'd99 : 8'd160;
      for (int j = 0; j < 24; j++) begin
        if (j == 0) mm = 23'd1;
        else if (j == 1) mm = 23'h7FFFFF;
        else if (j == 2) mm = 23'h400000;
        else mm = 23'($urandom_range(1, 32'h7FFFFF));
        run_op({1'b0, ee, mm}, 1'b0, 32'h0, 1'b0, 0);
      end
    end

    tick();
    chk("queue_drained", 32'(eq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
